io_access_sched: RTL

I/O access scheduler for the I/O decode block. It arbitrates between the CPU and the blitter/DSP for the shared I/O bus. It latches the winning address and direction, then sequences the bus through setup, strobe and hold phases. During those phases it drives the active-low chip-select, read and write strobes that the decode gates expect.

---
 rtl/io_sched_pkg.sv | 44 ++++
 rtl/io_region_dec.sv | 24 ++
 rtl/io_access_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/io_sched_pkg.sv
// Shared types and constants for the I/O access scheduler.
// Latency: none (types, constants and a pure arbitration helper only).
// Backpressure: none.
//
// Contents:
//   NCS     number of chip-select lines driven onto the I/O decode gates
//   RW      width of the region index taken from the top address bits
//   CNTW    width of the strobe wait counter (holds WAIT, legal 0..7)
//   state_t access sequencer states
//   gnt_t   identity of the requester owning the bus
//   rr_pick round-robin choice between the CPU and the blitter
package io_sched_pkg;

  localparam int NCS  = 8;
  localparam int RW   = 3;
  localparam int CNTW = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef enum logic {
    GNT_C = 1'b0,
    GNT_B = 1'b1
  } gnt_t;

  // Only meaningful when at least one request is high. On a tie the
  // requester that did not own the previous access wins, so a requester
  // that keeps its request up can never lock the other one out.
  function automatic gnt_t rr_pick(input logic creq, input logic breq,
                                   input gnt_t last);
    if (creq && breq) begin
      return (last == GNT_B) ? GNT_C : GNT_B;
    end else if (creq) begin
      return GNT_C;
    end else begin
      return GNT_B;
    end
  endfunction

endpackage

// File: rtl/io_region_dec.sv
// Region decoder: 3-to-8 active-low one-hot decode with a global enable.
// Latency: purely combinational, the caller registers the result.
// Backpressure: none.
//
// Ports:
//   idx  in  RW   region index (top address bits)
//   en   in  1    when low every output stays high (no region selected)
//   csl  out NCS  active-low select, exactly one line low when en is high
module io_region_dec
  import io_sched_pkg::*;
(
  input  logic [RW-1:0]  idx,
  input  logic           en,
  output logic [NCS-1:0] csl
);

  always_comb begin
    csl = '1;
    if (en) begin
      csl[idx] = 1'b0;
    end
  end

endmodule

// File: rtl/io_access_sched.sv
// I/O access scheduler: round-robin CPU/blitter arbiter plus the
// setup/strobe/hold sequencer for the shared I/O bus.
// Latency: request seen at edge n -> setup n+1, strobe n+2..n+2+WAIT,
//          ack n+3+WAIT, back in IDLE n+4+WAIT.
// Backpressure: requests are levels held until the one-cycle ACK pulse;
//               a requester not granted simply keeps its request up.
//
// Parameters:
//   AW    I/O address width, bits AW-1..AW-3 pick the chip-select region
//   WAIT  strobe cycles beyond the first, legal range 0..7
//
// Ports:
//   CLK, RESETL       clock, synchronous active-low reset
//   CREQ/CADDR/CWR    CPU request level, address, direction (1 = write)
//   CACK              CPU acknowledge pulse (HOLD phase)
//   BREQ/BADDR/BWR    blitter request level, address, direction
//   BACK              blitter acknowledge pulse (HOLD phase)
//   IOA               address latched at grant
//   CSL               active-low chip selects, one-hot low during an access
//   IORDL/IOWRL       active-low read/write strobes
//   BUSY              high whenever the sequencer is not idle
module io_access_sched
  import io_sched_pkg::*;
#(
  parameter int AW   = 8,
  parameter int WAIT = 2
) (
  input  logic           CLK,
  input  logic           RESETL,
  input  logic           CREQ,
  input  logic [AW-1:0]  CADDR,
  input  logic           CWR,
  output logic           CACK,
  input  logic           BREQ,
  input  logic [AW-1:0]  BADDR,
  input  logic           BWR,
  output logic           BACK,
  output logic [AW-1:0]  IOA,
  output logic [NCS-1:0] CSL,
  output logic           IORDL,
  output logic           IOWRL,
  output logic           BUSY
);

  localparam logic [CNTW-1:0] WAIT_LD = CNTW'(WAIT);

  state_t          state_q, state_d;
  gnt_t            gnt_q, gnt_d;     // owner of the current/most recent access
  logic            wr_q, wr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   ioa_d;
  logic [NCS-1:0]  csl_d;
  logic            strobe_d;
  logic            hold_d;
  logic            access_d;

  // Next-state logic. Address and direction are captured only on the IDLE
  // grant edge, so any change on the request buses during an access is
  // ignored until the sequencer is idle again.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    ioa_d   = IOA;

    case (state_q)
      IDLE: begin
        if (CREQ || BREQ) begin
          gnt_d   = rr_pick(CREQ, BREQ, gnt_q);
          ioa_d   = (gnt_d == GNT_C) ? CADDR : BADDR;
          wr_d    = (gnt_d == GNT_C) ? CWR : BWR;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = WAIT_LD;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        // Always pass through IDLE: it is the dead cycle that separates
        // back-to-back accesses and the only place a grant is made.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it,
  // so every output is a flop and none depends combinationally on inputs.
  assign access_d = (state_d != IDLE);
  assign strobe_d = (state_d == STROBE);
  assign hold_d   = (state_d == HOLD);

  io_region_dec u_region_dec (
    .idx (ioa_d[AW-1:AW-RW]),
    .en  (access_d),
    .csl (csl_d)
  );

  always_ff @(posedge CLK) begin
    if (!RESETL) begin
      state_q <= IDLE;
      gnt_q   <= GNT_B;       // CPU wins the first tie out of reset
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      IOA     <= '0;
      CSL     <= '1;
      IORDL   <= 1'b1;
      IOWRL   <= 1'b1;
      CACK    <= 1'b0;
      BACK    <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      IOA     <= ioa_d;
      CSL     <= csl_d;
      // Only one strobe can be low: both are gated by the single STROBE
      // state and split by the latched direction.
      IORDL   <= ~(strobe_d & ~wr_d);
      IOWRL   <= ~(strobe_d & wr_d);
      CACK    <= hold_d & (gnt_d == GNT_C);
      BACK    <= hold_d & (gnt_d == GNT_B);
      BUSY    <= access_d;
    end
  end

endmodule
